// File: rtl/regex_job_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : regex_job_sequencer_pkg
// Brief  : Shared command/status encodings, result codes and sequencer states.
// Rev    : 1.0
// ============================================================================
package regex_job_sequencer_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
    localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd2;
    localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd3;
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd4;
    localparam logic [REG_WIDTH-1:0] CMD_RESTART            = 32'd5;

    localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
    localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 32'd4;

    typedef enum logic [1:0] {
        RES_ACCEPT  = 2'd0,
        RES_REJECT  = 2'd1,
        RES_ERROR   = 2'd2,
        RES_TIMEOUT = 2'd3
    } res_code_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_RUN     = 3'd3,
        ST_READ_CC = 3'd4,
        ST_RESTART = 3'd5,
        ST_REPORT  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regex_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : regex_job_sequencer_if
// Brief  : Job, program-load and result handshakes of the job sequencer.
// Rev    : 1.0
// ============================================================================
interface regex_job_sequencer_if #(
    parameter int REG_WIDTH       = regex_job_sequencer_pkg::REG_WIDTH,
    parameter int PROG_ADDR_WIDTH = 10
);
    logic                     job_valid;
    logic                     job_ready;
    logic [PROG_ADDR_WIDTH:0] job_prog_len;
    logic [REG_WIDTH-1:0]     job_start_cc;
    logic [REG_WIDTH-1:0]     job_end_cc;

    logic                     prog_valid;
    logic                     prog_ready;
    logic [31:0]              prog_data;

    logic                     res_valid;
    logic                     res_ready;
    logic [1:0]               res_code;
    logic [REG_WIDTH-1:0]     res_elapsed;

    modport master (
        output job_valid, job_prog_len, job_start_cc, job_end_cc,
        input  job_ready,
        output prog_valid, prog_data,
        input  prog_ready,
        input  res_valid, res_code, res_elapsed,
        output res_ready
    );

    modport slave (
        input  job_valid, job_prog_len, job_start_cc, job_end_cc,
        output job_ready,
        input  prog_valid, prog_data,
        output prog_ready,
        output res_valid, res_code, res_elapsed,
        input  res_ready
    );
endinterface
`default_nettype wire

// File: rtl/regex_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module : regex_job_sequencer
// Brief  : Loads a regex program, starts a match run, watches it and reports.
// Rev    : 1.0
// ============================================================================
module regex_job_sequencer
    import regex_job_sequencer_pkg::*;
#(
    parameter int REG_WIDTH       = regex_job_sequencer_pkg::REG_WIDTH,
    parameter int PROG_ADDR_WIDTH = 10,
    parameter int TIMEOUT_WIDTH   = 24
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    regex_job_sequencer_if.slave          bus,
    input  wire logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    output logic [REG_WIDTH-1:0]          cmd_register,
    output logic [REG_WIDTH-1:0]          address_register,
    output logic [REG_WIDTH-1:0]          data_in_register,
    output logic [REG_WIDTH-1:0]          start_cc_pointer_register,
    output logic [REG_WIDTH-1:0]          end_cc_pointer_register,
    input  wire logic [REG_WIDTH-1:0]     status_register,
    input  wire logic [REG_WIDTH-1:0]     data_o_register
);

    localparam int IDX_W = PROG_ADDR_WIDTH + 1;
    localparam logic [IDX_W-1:0] c_max_len = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

    localparam logic [REG_WIDTH-1:0] c_cmd_nop     = REG_WIDTH'(CMD_NOP);
    localparam logic [REG_WIDTH-1:0] c_cmd_write   = REG_WIDTH'(CMD_WRITE);
    localparam logic [REG_WIDTH-1:0] c_cmd_start   = REG_WIDTH'(CMD_START);
    localparam logic [REG_WIDTH-1:0] c_cmd_reset   = REG_WIDTH'(CMD_RESET);
    localparam logic [REG_WIDTH-1:0] c_cmd_read    = REG_WIDTH'(CMD_READ_ELAPSED_CLOCK);
    localparam logic [REG_WIDTH-1:0] c_cmd_restart = REG_WIDTH'(CMD_RESTART);

    // Reset asserts asynchronously but is released only after two clock edges.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t                   r_state;
    logic [IDX_W-1:0]         r_len;
    logic [IDX_W-1:0]         r_idx;
    logic [TIMEOUT_WIDTH-1:0] r_wdog;
    logic                     r_rd_phase;
    logic [REG_WIDTH-1:0]     r_cmd;
    logic [REG_WIDTH-1:0]     r_addr;
    logic [REG_WIDTH-1:0]     r_data;
    logic [REG_WIDTH-1:0]     r_start_cc;
    logic [REG_WIDTH-1:0]     r_end_cc;
    logic                     r_job_ready;
    logic                     r_prog_ready;
    logic                     r_res_valid;
    res_code_t                r_res_code;
    logic [REG_WIDTH-1:0]     r_res_elapsed;

    logic [IDX_W-1:0] w_len_clamped;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_st_running;
    logic             w_st_idle;
    logic             w_done;
    res_code_t        w_done_code;
    logic             w_timeout_hit;

    assign w_len_clamped = (bus.job_prog_len > c_max_len) ? c_max_len : bus.job_prog_len;
    assign w_idx_next    = r_idx + IDX_W'(1);
    assign w_st_running  = (status_register == REG_WIDTH'(STATUS_RUNNING));
    assign w_st_idle     = (status_register == REG_WIDTH'(STATUS_IDLE));
    assign w_timeout_hit = (timeout_cycles != '0) && (r_wdog == timeout_cycles);

    always_comb begin
        w_done      = 1'b1;
        w_done_code = RES_ACCEPT;
        if (status_register == REG_WIDTH'(STATUS_ACCEPTED)) begin
            w_done_code = RES_ACCEPT;
        end else if (status_register == REG_WIDTH'(STATUS_REJECTED)) begin
            w_done_code = RES_REJECT;
        end else if (status_register == REG_WIDTH'(STATUS_ERROR)) begin
            w_done_code = RES_ERROR;
        end else begin
            w_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_idx         <= '0;
            r_wdog        <= '0;
            r_rd_phase    <= 1'b0;
            r_cmd         <= c_cmd_nop;
            r_addr        <= '0;
            r_data        <= '0;
            r_start_cc    <= '0;
            r_end_cc      <= '0;
            r_job_ready   <= 1'b1;
            r_prog_ready  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_code    <= RES_ACCEPT;
            r_res_elapsed <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd       <= c_cmd_nop;
                    r_job_ready <= 1'b1;
                    if (bus.job_valid) begin
                        r_len       <= w_len_clamped;
                        r_idx       <= '0;
                        r_start_cc  <= bus.job_start_cc;
                        r_end_cc    <= bus.job_end_cc;
                        r_job_ready <= 1'b0;
                        if (w_len_clamped != '0) begin
                            r_prog_ready <= 1'b1;
                            r_state      <= ST_LOAD;
                        end else begin
                            r_cmd   <= c_cmd_start;
                            r_state <= ST_START;
                        end
                    end
                end
                ST_LOAD: begin
                    r_cmd <= c_cmd_nop;
                    if (bus.prog_valid) begin
                        r_cmd  <= c_cmd_write;
                        r_addr <= REG_WIDTH'(r_idx);
                        r_data <= REG_WIDTH'(bus.prog_data);
                        r_idx  <= w_idx_next;
                        // Last word: its write is still on the bus during the first START cycle.
                        if (w_idx_next == r_len) begin
                            r_prog_ready <= 1'b0;
                            r_state      <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    if (r_cmd == c_cmd_start && w_st_running) begin
                        r_cmd   <= c_cmd_nop;
                        r_wdog  <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_cmd <= c_cmd_start;
                    end
                end
                ST_RUN: begin
                    r_cmd <= c_cmd_nop;
                    if (w_done) begin
                        r_res_code <= w_done_code;
                        r_cmd      <= c_cmd_read;
                        r_rd_phase <= 1'b0;
                        r_state    <= ST_READ_CC;
                    end else if (w_timeout_hit) begin
                        r_cmd         <= c_cmd_reset;
                        r_res_code    <= RES_TIMEOUT;
                        r_res_elapsed <= REG_WIDTH'(r_wdog);
                        r_res_valid   <= 1'b1;
                        r_state       <= ST_REPORT;
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + TIMEOUT_WIDTH'(1);
                    end
                end
                ST_READ_CC: begin
                    r_cmd      <= c_cmd_nop;
                    r_rd_phase <= ~r_rd_phase;
                    if (r_rd_phase) begin
                        r_res_elapsed <= data_o_register;
                        r_cmd         <= c_cmd_restart;
                        r_state       <= ST_RESTART;
                    end
                end
                ST_RESTART: begin
                    if (r_cmd == c_cmd_restart && w_st_idle) begin
                        r_cmd       <= c_cmd_nop;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_REPORT;
                    end else begin
                        r_cmd <= c_cmd_restart;
                    end
                end
                ST_REPORT: begin
                    r_cmd <= c_cmd_nop;
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_register              = r_cmd;
    assign address_register          = r_addr;
    assign data_in_register          = r_data;
    assign start_cc_pointer_register = r_start_cc;
    assign end_cc_pointer_register   = r_end_cc;
    assign bus.job_ready             = r_job_ready;
    assign bus.prog_ready            = r_prog_ready;
    assign bus.res_valid             = r_res_valid;
    assign bus.res_code              = r_res_code;
    assign bus.res_elapsed           = r_res_elapsed;

endmodule
`default_nettype wire

// File: doc/regex_job_sequencer.md
REGEX_JOB_SEQUENCER -- requirements
Module: regex_job_sequencer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32 (package value), meaning register and data width.
REQ-002 SHALL have parameter PROG_ADDR_WIDTH, default 10, meaning the 32-bit word address width of the program memory.
REQ-003 SHALL have parameter TIMEOUT_WIDTH, default 24, meaning the run watchdog counter width.
REQ-004 SHALL have ports: clk  in  1  single clock; rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports: job_valid  in  1; job_ready  out  1; job_prog_len  in  PROG_ADDR_WIDTH+1  words to load (0 = reuse resident program); job_start_cc  in  REG_WIDTH; job_end_cc  in  REG_WIDTH.
REQ-006 SHALL have ports: prog_valid  in  1; prog_ready  out  1; prog_data  in  32  program word.
REQ-007 SHALL have port: timeout_cycles  in  TIMEOUT_WIDTH  watchdog limit (0 = disabled).
REQ-008 SHALL have ports to the downstream command block: cmd_register, address_register, data_in_register, start_cc_pointer_register, end_cc_pointer_register  out  REG_WIDTH each; status_register, data_o_register  in  REG_WIDTH each.
REQ-009 SHALL have ports: res_valid  out  1; res_ready  in  1; res_code  out  2  (0 accept, 1 reject, 2 error, 3 timeout); res_elapsed  out  REG_WIDTH  cycle count.

Function
REQ-010 All outputs SHALL be registered; at reset: cmd=CMD_NOP, all pointers/address/data=0, job_ready=1, prog_ready=0, res_valid=0, res_code=0, res_elapsed=0.
REQ-011 FSM states: IDLE, LOAD, START, RUN, READ_CC, RESTART, REPORT.
REQ-012 IDLE: job_ready=1, cmd=CMD_NOP; on job_valid, latch len/start_cc/end_cc, clear word index, go LOAD if len!=0, else START.
REQ-013 LOAD: prog_ready=1; each cycle with prog_valid: next-cycle cmd=CMD_WRITE, address=index, data=prog_data, index+1; cycles without prog_valid drive CMD_NOP (no write).
REQ-014 LOAD SHALL exit to START on the cycle after the write of word len-1 is issued; exactly len writes, addresses 0..len-1.
REQ-015 START: drive CMD_START with both cc pointers held; stay until status_register==STATUS_RUNNING, then cmd=CMD_NOP, clear watchdog, go RUN.
REQ-016 RUN: cmd=CMD_NOP; watchdog +1 per cycle; status ACCEPTED/REJECTED/ERROR -> latch code 0/1/2, go READ_CC.
REQ-017 RUN: if timeout_cycles!=0 and watchdog==timeout_cycles, drive CMD_RESET for exactly one cycle, code=3, elapsed=watchdog, go REPORT; completion in the same cycle takes priority over timeout.
REQ-018 READ_CC: drive CMD_READ_ELAPSED_CLOCK one cycle; capture data_o_register on the following cycle into res_elapsed; go RESTART.
REQ-019 RESTART: drive CMD_RESTART until status_register==STATUS_IDLE, then CMD_NOP, go REPORT.
REQ-020 REPORT: res_valid=1, outputs stable until res_ready; on handshake res_valid=0, go IDLE same edge.
REQ-021 job_ready SHALL be 0 in every state except IDLE; prog_ready SHALL be 0 outside LOAD.
REQ-022 Word index SHALL not wrap; len > 2^PROG_ADDR_WIDTH SHALL be clamped to 2^PROG_ADDR_WIDTH.
REQ-023 Watchdog SHALL saturate at all-ones when disabled.

Reset
REQ-024 Assertion of rst at any time SHALL asynchronously return FSM to IDLE with REQ-010 values; an in-flight job is dropped, no result emitted.
REQ-025 Deassertion SHALL be used synchronously via a two-flop synchronizer inside the block.

Structure
REQ-026 CMD_* and STATUS_* constants and REG_WIDTH SHALL come from the shared AXI package; result-code typedef and FSM state enum SHALL be added to it.
REQ-027 No sub-module required; watchdog counter SHALL be inline.

Verification
REQ-028 Load: len=3, words 0xA,0xB,0xC with a 1-cycle prog_valid gap -> CMD_WRITE at addr 0,1,2 with matching data, one CMD_NOP cycle during gap.
REQ-029 Accept: len=0, status model RUNNING 2 cycles after CMD_START, ACCEPTED after 50, data_o=50 -> res_code=0, res_elapsed=50, then CMD_RESTART until IDLE.
REQ-030 Timeout: timeout_cycles=20, model never completes -> single CMD_RESET cycle 20 cycles into RUN, res_code=3, res_elapsed=20.
REQ-031 Backpressure: res_ready low 10 cycles -> res_valid/res_code/res_elapsed stable, job_ready=0 throughout.
REQ-032 Reset mid-LOAD after word 1 of 4 -> next cycle all outputs at reset values, no result, job_ready=1.
REQ-033 Simultaneous: status ERROR on watchdog==limit cycle -> res_code=2, no CMD_RESET.
